// File: rtl/mdu_pkg.sv
// Shared types and op-classification helpers for the MIPS multiply/divide unit.
package mdu_pkg;

    typedef enum logic [3:0] {
        MDU_NONE  = 4'd0,
        MDU_MULT  = 4'd1,
        MDU_MULTU = 4'd2,
        MDU_DIV   = 4'd3,
        MDU_DIVU  = 4'd4,
        MDU_MTHI  = 4'd5,
        MDU_MTLO  = 4'd6,
        MDU_MFHI  = 4'd7,
        MDU_MFLO  = 4'd8
    } mdu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } mdu_state_e;

    // Multi-cycle ops that occupy the unit and hold EX until DONE.
    function automatic logic is_long_op(input mdu_op_e op);
        return op inside {MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU};
    endfunction

    function automatic logic is_div_op(input mdu_op_e op);
        return op inside {MDU_DIV, MDU_DIVU};
    endfunction

    // Two's-complement interpretation of the operands.
    function automatic logic is_signed_op(input mdu_op_e op);
        return op inside {MDU_MULT, MDU_DIV};
    endfunction

    function automatic logic is_mf_op(input mdu_op_e op);
        return op inside {MDU_MFHI, MDU_MFLO};
    endfunction

endpackage

// File: rtl/mdu_div_iter.sv
// Iterative restoring divider on operand magnitudes. Retires DIV_BPC
// quotient bits per cycle, W/DIV_BPC cycles after start, and applies the
// quotient/remainder sign correction on the way out.
module mdu_div_iter #(
    parameter int W       = 32,
    parameter int DIV_BPC = 1
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         start,
    input  logic         kill,
    input  logic [W-1:0] mag_a,
    input  logic [W-1:0] mag_b,
    input  logic         neg_q,
    input  logic         neg_r,
    output logic         done,
    output logic [W-1:0] quo,
    output logic [W-1:0] rem
);

    localparam int ITERS = W / DIV_BPC;
    localparam int CNTW  = $clog2(ITERS + 1);
    localparam logic [CNTW-1:0] CNT_LAST = CNTW'(ITERS - 1);

    logic            run;
    logic [CNTW-1:0] cnt;
    logic [W-1:0]    rem_q;
    logic [W-1:0]    quo_q;
    logic [W-1:0]    dvs_q;
    logic            neg_q_q;
    logic            neg_r_q;

    logic [W:0]      it_r;
    logic [W:0]      it_d;
    logic [W-1:0]    it_q;

    // done is high during the cycle whose edge retires the final bits.
    assign done = run && (cnt == CNT_LAST);

    // One cycle of restoring division: DIV_BPC shift/compare/subtract steps.
    always_comb begin
        it_r = {1'b0, rem_q};
        it_q = quo_q;
        it_d = '0;
        for (int k = 0; k < DIV_BPC; k++) begin
            it_r = {it_r[W-1:0], it_q[W-1]};
            it_q = {it_q[W-2:0], 1'b0};
            it_d = it_r - {1'b0, dvs_q};
            if (!it_d[W]) begin
                it_r    = it_d;
                it_q[0] = 1'b1;
            end
        end
    end

    // Iteration control: run flag and cycle counter, cleared by kill.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            run <= 1'b0;
            cnt <= '0;
        end else if (kill) begin
            run <= 1'b0;
            cnt <= '0;
        end else if (start) begin
            run <= 1'b1;
            cnt <= '0;
        end else if (run) begin
            if (cnt == CNT_LAST) begin
                run <= 1'b0;
                cnt <= '0;
            end else begin
                cnt <= cnt + CNTW'(1);
            end
        end
    end

    // Datapath: load magnitudes on start, then shift in quotient bits.
    always_ff @(posedge clk) begin
        if (start) begin
            rem_q   <= '0;
            quo_q   <= mag_a;
            dvs_q   <= mag_b;
            neg_q_q <= neg_q;
            neg_r_q <= neg_r;
        end else if (run) begin
            rem_q <= it_r[W-1:0];
            quo_q <= it_q;
        end
    end

    // Sign-fix output stage: quotient negated on differing signs,
    // remainder follows the dividend.
    assign quo = neg_q_q ? -quo_q : quo_q;
    assign rem = neg_r_q ? -rem_q : rem_q;

endmodule

// File: rtl/mdu_hilo_unit.sv
// MIPS multiply/divide unit with architectural HI/LO. Long ops hold EX via
// stall until the DONE cycle, where the result is written and bypassed to MF.
module mdu_hilo_unit
    import mdu_pkg::*;
#(
    parameter int W          = 32,
    parameter int MUL_STAGES = 2,
    parameter int DIV_BPC    = 1
) (
    input  logic           clk,
    input  logic           resetn,
    input  logic           req_valid,
    input  mdu_op_e        req_op,
    input  logic [W-1:0]   rs,
    input  logic [W-1:0]   rt,
    input  logic           flush,
    output logic           stall,
    output logic [W-1:0]   mf_res,
    output logic [2*W-1:0] hilo,
    output logic           busy
);

    localparam logic [2:0] MUL_LAST = 3'(MUL_STAGES - 1);

    // Full 2W-bit product; sign/zero extension to 2W bits makes the
    // modulo-2^(2W) product exact for both MULT and MULTU.
    function automatic logic signed [2*W-1:0] mul_full(input logic [W-1:0] a,
                                                       input logic [W-1:0] b,
                                                       input logic         sgn);
        logic signed [2*W-1:0] ea;
        logic signed [2*W-1:0] eb;
        ea = {{W{sgn & a[W-1]}}, a};
        eb = {{W{sgn & b[W-1]}}, b};
        return ea * eb;
    endfunction

    function automatic logic [W-1:0] mag_of(input logic [W-1:0] v, input logic sgn);
        return (sgn && v[W-1]) ? -v : v;
    endfunction

    mdu_state_e            state;
    mdu_op_e               op_q;
    logic [W-1:0]          hi;
    logic [W-1:0]          lo;
    logic [W-1:0]          op_a;
    logic [W-1:0]          op_b;
    logic [2:0]            mul_cnt;
    logic signed [2*W-1:0] prod_p [MUL_STAGES];

    logic                  launch;
    logic                  launch_sgn;
    logic                  mt_ok;
    logic                  div_start;
    logic                  div_done;
    logic [W-1:0]          div_mag_a;
    logic [W-1:0]          div_mag_b;
    logic                  div_neg_q;
    logic                  div_neg_r;
    logic [W-1:0]          div_quo;
    logic [W-1:0]          div_rem;
    logic [W-1:0]          res_hi;
    logic [W-1:0]          res_lo;
    logic [W-1:0]          hi_view;
    logic [W-1:0]          lo_view;

    assign busy       = (state == ST_MUL) || (state == ST_DIV);
    assign launch     = (state == ST_IDLE) && req_valid && is_long_op(req_op) && !flush;
    assign launch_sgn = is_signed_op(req_op);
    assign stall      = busy || launch || (req_valid && is_mf_op(req_op) && busy);
    assign mt_ok      = req_valid && !stall && !flush;
    assign hilo       = {hi, lo};

    assign div_start  = launch && is_div_op(req_op);
    assign div_mag_a  = mag_of(rs, launch_sgn);
    assign div_mag_b  = mag_of(rt, launch_sgn);
    assign div_neg_q  = launch_sgn && (rs[W-1] ^ rt[W-1]);
    assign div_neg_r  = launch_sgn && rs[W-1];

    mdu_div_iter #(
        .W       (W),
        .DIV_BPC (DIV_BPC)
    ) u_div (
        .clk    (clk),
        .resetn (resetn),
        .start  (div_start),
        .kill   (flush),
        .mag_a  (div_mag_a),
        .mag_b  (div_mag_b),
        .neg_q  (div_neg_q),
        .neg_r  (div_neg_r),
        .done   (div_done),
        .quo    (div_quo),
        .rem    (div_rem)
    );

    // Operand capture at issue; shared by multiplier and divide-by-zero fixup.
    always_ff @(posedge clk) begin
        if (launch) begin
            op_a <= rs;
            op_b <= rt;
        end
    end

    // Multiplier pipeline: stage 0 forms the product, later stages carry it.
    always_ff @(posedge clk) begin
        if (state == ST_MUL) begin
            prod_p[0] <= mul_full(op_a, op_b, op_q == MDU_MULT);
            for (int i = 1; i < MUL_STAGES; i++) begin
                prod_p[i] <= prod_p[i-1];
            end
        end
    end

    // Result select for the DONE cycle, including divider corner cases.
    always_comb begin
        res_hi = '0;
        res_lo = '0;
        if (!is_div_op(op_q)) begin
            {res_hi, res_lo} = prod_p[MUL_STAGES-1];
        end else if (op_b == '0) begin
            res_hi = op_a;
            res_lo = '1;
        end else begin
            res_hi = div_rem;
            res_lo = div_quo;
        end
    end

    // MF readout, bypassing the result being written in DONE.
    always_comb begin
        hi_view = hi;
        lo_view = lo;
        if (state == ST_DONE && !flush) begin
            hi_view = res_hi;
            lo_view = res_lo;
        end
        mf_res = '0;
        if (req_valid && req_op == MDU_MFHI) begin
            mf_res = hi_view;
        end else if (req_valid && req_op == MDU_MFLO) begin
            mf_res = lo_view;
        end
    end

    // Control FSM plus the architectural HI/LO registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state   <= ST_IDLE;
            op_q    <= MDU_NONE;
            mul_cnt <= '0;
            hi      <= '0;
            lo      <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (launch) begin
                        op_q    <= req_op;
                        mul_cnt <= '0;
                        state   <= is_div_op(req_op) ? ST_DIV : ST_MUL;
                    end
                end
                ST_MUL: begin
                    if (flush) begin
                        state   <= ST_IDLE;
                        mul_cnt <= '0;
                    end else if (mul_cnt == MUL_LAST) begin
                        state   <= ST_DONE;
                        mul_cnt <= '0;
                    end else begin
                        mul_cnt <= mul_cnt + 3'd1;
                    end
                end
                ST_DIV: begin
                    if (flush) begin
                        state <= ST_IDLE;
                    end else if (div_done) begin
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (!flush) begin
                        hi <= res_hi;
                        lo <= res_lo;
                    end
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
            if (mt_ok && req_op == MDU_MTHI) begin
                hi <= rs;
            end
            if (mt_ok && req_op == MDU_MTLO) begin
                lo <= rs;
            end
        end
    end

endmodule

// File: tb/tb_mdu_hilo_unit.sv
// Directed bench for mdu_hilo_unit: three instances (DIV_BPC 1, 2, 4) share
// operands/op/flush; each has its own req_valid.
module tb_mdu_hilo_unit;
    import mdu_pkg::*;

    logic        clk;
    logic        resetn;
    logic [31:0] rs;
    logic [31:0] rt;
    mdu_op_e     req_op;
    logic        flush;
    logic        rv      [3];
    logic        stall_v [3];
    logic        busy_v  [3];
    logic [31:0] mf_v    [3];
    logic [63:0] hilo_v  [3];

    int n_chk  = 0;
    int n_fail = 0;
    int ncyc;
    logic [31:0] mf_done;
    logic [63:0] saved;
    logic [31:0] a;
    logic [31:0] b;
    mdu_op_e     op;

    mdu_hilo_unit #(.W(32), .MUL_STAGES(2), .DIV_BPC(1)) dut0 (
        .clk(clk), .resetn(resetn), .req_valid(rv[0]), .req_op(req_op),
        .rs(rs), .rt(rt), .flush(flush), .stall(stall_v[0]),
        .mf_res(mf_v[0]), .hilo(hilo_v[0]), .busy(busy_v[0]));

    mdu_hilo_unit #(.W(32), .MUL_STAGES(2), .DIV_BPC(2)) dut1 (
        .clk(clk), .resetn(resetn), .req_valid(rv[1]), .req_op(req_op),
        .rs(rs), .rt(rt), .flush(flush), .stall(stall_v[1]),
        .mf_res(mf_v[1]), .hilo(hilo_v[1]), .busy(busy_v[1]));

    mdu_hilo_unit #(.W(32), .MUL_STAGES(2), .DIV_BPC(4)) dut2 (
        .clk(clk), .resetn(resetn), .req_valid(rv[2]), .req_op(req_op),
        .rs(rs), .rt(rt), .flush(flush), .stall(stall_v[2]),
        .mf_res(mf_v[2]), .hilo(hilo_v[2]), .busy(busy_v[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one long op on instance d; count stall cycles (bounded) and
    // capture mf_res in the DONE cycle, then retire the instruction.
    task automatic long_op(input int d, input mdu_op_e o, input logic [31:0] x,
                           input logic [31:0] y, input bit mf_follow,
                           output int n, output logic [31:0] mf);
        step();
        rs = x; rt = y; req_op = o; rv[d] = 1'b1;
        n = 0;
        @(negedge clk);
        while (stall_v[d] === 1'b1 && n < 100) begin
            n++;
            step();
            if (mf_follow) req_op = MDU_MFLO;
            @(negedge clk);
        end
        mf = mf_v[d];
        step();
        rv[d] = 1'b0; req_op = MDU_NONE;
        @(negedge clk);
    endtask

    function automatic logic [63:0] div_ref(input bit sgn, input logic [31:0] x, input logic [31:0] y);
        logic [31:0] q;
        logic [31:0] r;
        if (y == 32'h0) return {x, 32'hFFFF_FFFF};
        if (sgn) begin
            if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
            q = 32'($signed(x) / $signed(y));
            r = 32'($signed(x) % $signed(y));
        end else begin
            q = x / y;
            r = x % y;
        end
        return {r, q};
    endfunction

    initial begin
        resetn = 1'b0; flush = 1'b0; rs = '0; rt = '0; req_op = MDU_NONE;
        for (int d = 0; d < 3; d++) rv[d] = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("reset_hilo%0d", d), hilo_v[d], 64'h0);
            chk($sformatf("reset_stall%0d", d), 64'(stall_v[d]), 64'h0);
            chk($sformatf("reset_busy%0d", d), 64'(busy_v[d]), 64'h0);
            chk($sformatf("reset_mf%0d", d), 64'(mf_v[d]), 64'h0);
        end
        resetn = 1'b1;

        // MTHI then observe HI
        step();
        rv[0] = 1'b1; req_op = MDU_MTHI; rs = 32'h1234_5678;
        @(negedge clk);
        chk("mthi_stall", 64'(stall_v[0]), 64'h0);
        step();
        rv[0] = 1'b0; req_op = MDU_NONE;
        @(negedge clk);
        chk("mthi_hilo", hilo_v[0], 64'h1234_5678_0000_0000);

        // MTLO then MFLO/MFHI back-to-back
        step();
        rv[0] = 1'b1; req_op = MDU_MTLO; rs = 32'hCAFE_BABE;
        step();
        req_op = MDU_MFLO; rs = 32'h0;
        @(negedge clk);
        chk("mf_after_mt_stall", 64'(stall_v[0]), 64'h0);
        chk("mflo_after_mtlo", 64'(mf_v[0]), 64'hCAFE_BABE);
        step();
        req_op = MDU_MFHI;
        @(negedge clk);
        chk("mfhi", 64'(mf_v[0]), 64'h1234_5678);
        step();
        rv[0] = 1'b0; req_op = MDU_NONE;

        // Flushed MTHI must not write
        rv[0] = 1'b1; req_op = MDU_MTHI; rs = 32'hDEAD_BEEF; flush = 1'b1;
        step();
        rv[0] = 1'b0; req_op = MDU_NONE; flush = 1'b0;
        @(negedge clk);
        chk("mt_flushed", hilo_v[0], 64'h1234_5678_CAFE_BABE);

        // Flushed long op in IDLE does not stall or launch
        step();
        rv[0] = 1'b1; req_op = MDU_MULT; rs = 32'd3; rt = 32'd4; flush = 1'b1;
        @(negedge clk);
        chk("flush_idle_stall", 64'(stall_v[0]), 64'h0);
        step();
        rv[0] = 1'b0; req_op = MDU_NONE; flush = 1'b0;
        @(negedge clk);
        chk("flush_idle_busy", 64'(busy_v[0]), 64'h0);

        // Multiplies
        long_op(0, MDU_MULT, 32'hFFFF_FFFE, 32'd3, 1'b0, ncyc, mf_done);
        chk("mult_stall_cycles", 64'(ncyc), 64'd3);
        chk("mult_hilo", hilo_v[0], 64'hFFFF_FFFF_FFFF_FFFA);
        long_op(0, MDU_MULTU, 32'hFFFF_FFFE, 32'd3, 1'b0, ncyc, mf_done);
        chk("multu_stall_cycles", 64'(ncyc), 64'd3);
        chk("multu_hilo", hilo_v[0], 64'h0000_0002_FFFF_FFFA);
        long_op(0, MDU_MULT, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, ncyc, mf_done);
        chk("mult_mflo_stall_cycles", 64'(ncyc), 64'd3);
        chk("mflo_bypass_done", 64'(mf_done), 64'h8000_0000);
        chk("mult_min_hilo", hilo_v[0], 64'h0000_0000_8000_0000);

        // Divides
        long_op(0, MDU_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0, ncyc, mf_done);
        chk("div_stall_cycles", 64'(ncyc), 64'd33);
        chk("div_neg7_2", hilo_v[0], 64'hFFFF_FFFF_FFFF_FFFD);
        long_op(0, MDU_DIVU, 32'd7, 32'd0, 1'b0, ncyc, mf_done);
        chk("divu_zero_cycles", 64'(ncyc), 64'd33);
        chk("divu_by_zero", hilo_v[0], 64'h0000_0007_FFFF_FFFF);
        long_op(0, MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, ncyc, mf_done);
        chk("div_overflow", hilo_v[0], 64'h0000_0000_8000_0000);
        long_op(0, MDU_DIV, 32'd100, 32'hFFFF_FFF9, 1'b0, ncyc, mf_done);
        chk("div_100_neg7", hilo_v[0], 64'h0000_0002_FFFF_FFF2);

        // DIV killed by flush at cycle 10
        saved = hilo_v[0];
        step();
        rv[0] = 1'b1; req_op = MDU_DIV; rs = 32'd100; rt = 32'd7;
        repeat (10) step();
        flush = 1'b1;
        @(negedge clk);
        chk("flush_div_busy_before", 64'(busy_v[0]), 64'h1);
        step();
        flush = 1'b0; rv[0] = 1'b0; req_op = MDU_NONE;
        @(negedge clk);
        chk("flush_div_busy_after", 64'(busy_v[0]), 64'h0);
        chk("flush_div_stall_after", 64'(stall_v[0]), 64'h0);
        chk("flush_div_hilo", hilo_v[0], saved);
        repeat (40) step();
        @(negedge clk);
        chk("flush_div_hilo_later", hilo_v[0], saved);

        // DIV_BPC=2 and 4 sweep against the reference model
        for (int i = 0; i < 6; i++) begin
            for (int d = 1; d < 3; d++) begin
                a = $urandom;
                if (i % 3 == 0) b = 32'($urandom_range(1, 15));
                else if (i % 3 == 1) b = -32'($urandom_range(1, 15));
                else b = $urandom;
                if (i == 4) b = 32'h0;
                op = (i % 2 == 1) ? MDU_DIV : MDU_DIVU;
                long_op(d, op, a, b, 1'b0, ncyc, mf_done);
                chk($sformatf("sweep_cycles_d%0d_i%0d", d, i), 64'(ncyc), (d == 1) ? 64'd17 : 64'd9);
                chk($sformatf("sweep_hilo_d%0d_i%0d", d, i), hilo_v[d], div_ref(op == MDU_DIV, a, b));
            end
        end

        // Asynchronous reset during a multiply
        step();
        rv[0] = 1'b1; req_op = MDU_MULTU; rs = 32'd5; rt = 32'd7;
        step();
        rv[0] = 1'b0; req_op = MDU_NONE;
        #2 resetn = 1'b0;
        #1;
        chk("async_reset_busy", 64'(busy_v[0]), 64'h0);
        chk("async_reset_hilo", hilo_v[0], 64'h0);
        @(negedge clk);
        resetn = 1'b1;
        step();

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
